// File: rtl/req_enc32t5.sv
// req_enc32t5: registered 2**W-to-W request encoder with sticky pending vector and valid/ready handshake
// Ports:
//   Clk    - clock, rising edge
//   Rst_n  - asynchronous active-low reset
//   Req    - request pulses, bit i sets Pend[i] at the next edge
//   En     - allows a new index to be loaded for presentation
//   Flush  - synchronous clear of Pend and of any presented item
//   Ready  - consumer accepts Code when Valid & Ready
//   Valid  - Code holds a pending index
//   Code   - presented index (registered)
//   Pend   - pending vector (registered)
module req_enc32t5 #(
    parameter int W         = 5,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [2**W-1:0] Req,
    input  logic            En,
    input  logic            Flush,
    input  logic            Ready,
    output logic            Valid,
    output logic [W-1:0]    Code,
    output logic [2**W-1:0] Pend
);
    localparam int N = 2**W;

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   code_nxt;
    logic [N-1:0]   pend_nxt, clr, rem;
    logic           accept;

    // Priority encoder over the registered pending bits only.
    function automatic logic [W-1:0] sel(input logic [N-1:0] v);
        sel = '0;
        if (LSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--) if (v[i]) sel = W'(i);
        end else begin
            for (int i = 0; i < N; i++) if (v[i]) sel = W'(i);
        end
    endfunction

    assign Valid  = (state == PRESENT);
    assign accept = Valid && Ready;
    assign clr    = accept ? (N'(1) << Code) : '0;
    assign rem    = Pend & ~clr;

    always_comb begin
        state_nxt = state;
        code_nxt  = Code;
        // A request arriving on the bit being accepted re-sets it (set wins).
        pend_nxt  = Flush ? '0 : (rem | Req);
        if (Flush) begin
            state_nxt = IDLE;
        end else if (state == IDLE) begin
            if (En && |Pend) begin
                state_nxt = PRESENT;
                code_nxt  = sel(Pend);
            end
        end else if (accept) begin
            if (En && |rem) code_nxt = sel(rem);
            else state_nxt = IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            Code  <= '0;
            Pend  <= '0;
        end else begin
            state <= state_nxt;
            Code  <= code_nxt;
            Pend  <= pend_nxt;
        end
    end
endmodule
